// File: rtl/blink_pkg.sv
// Shared types and constants for the LED blink sequencer.
package blink_pkg;

   // Display mode, stepped in declaration order by the mode button
   typedef enum logic [1:0] {
      MODE_BLINK = 2'd0,
      MODE_CHASE = 2'd1,
      MODE_COUNT = 2'd2,
      MODE_OFF   = 2'd3
   } mode_t;

   // Speed index: 0 is fastest, SPEED_MAX slowest (period doubles per step)
   localparam int SPEED_W = 3;
   localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;

   // Mode that follows m; OFF wraps back to BLINK
   function automatic mode_t next_mode(input mode_t m);
      logic [1:0] v;
      v = m;
      v = v + 2'd1;
      return mode_t'(v);
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, stability debouncer and rising-edge press pulse
// for one asynchronous push button.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 12000
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta;
   logic             sync;
   logic [CNT_W-1:0] count;
   logic             accept;

   // Bring the raw button into the clock domain
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= raw;
         sync <= meta;
      end
   end

   // The new value is taken on the last of DEBOUNCE_CYCLES consecutive differing samples
   assign accept = (sync != level) && (count == CNT_LAST);

   // Count consecutive samples that disagree with the accepted level
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         count <= '0;
         level <= 1'b0;
      end else if (sync == level) begin
         count <= '0;
      end else if (accept) begin
         count <= '0;
         level <= sync;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

   // One-cycle pulse on the edge where the level goes high; holding gives no more
   assign press = accept && sync;

endmodule

// File: rtl/blink_sequencer.sv
// LED pattern sequencer: three debounced buttons select the display mode
// and the tick rate; the pattern register steps once per tick.
module blink_sequencer
   import blink_pkg::*;
#(
   parameter int N_LEDS          = 5,
   parameter int DIV_BASE        = 500000,
   parameter int DEBOUNCE_CYCLES = 12000
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              BTN1,
   input  logic              BTN2,
   input  logic              BTN3,
   output logic [N_LEDS-1:0] LEDS
);

   // Wide enough for DIV_BASE << SPEED_MAX minus one
   localparam int DIV_W = $clog2(DIV_BASE) + 7;

   logic               press_mode;
   logic               press_fast;
   logic               press_slow;
   mode_t              mode;
   mode_t              mode_next;
   logic [SPEED_W-1:0] speed;
   logic [SPEED_W-1:0] speed_next;
   logic               speed_change;
   logic [DIV_W:0]     period;
   logic [DIV_W-1:0]   period_last;
   logic [DIV_W-1:0]   div_count;
   logic               tick;
   logic [N_LEDS-1:0]  pattern;
   logic [N_LEDS-1:0]  pattern_step;
   logic [N_LEDS-1:0]  pattern_init;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_mode (
      .CLK   (CLK),
      .RST_N (RST_N),
      .raw   (BTN1),
      .level (),
      .press (press_mode)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_fast (
      .CLK   (CLK),
      .RST_N (RST_N),
      .raw   (BTN2),
      .level (),
      .press (press_fast)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_slow (
      .CLK   (CLK),
      .RST_N (RST_N),
      .raw   (BTN3),
      .level (),
      .press (press_slow)
   );

   // Mode state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) mode <= MODE_BLINK;
      else        mode <= mode_next;
   end

   // Mode advances one step per mode-button press
   always_comb begin
      mode_next = mode;
      if (press_mode) mode_next = next_mode(mode);
   end

   // Mode-dependent outputs: next pattern on a tick, and load value on entry
   always_comb begin
      pattern_init = '0;
      if (mode_next == MODE_CHASE) pattern_init = N_LEDS'(1);
      case (mode)
         MODE_BLINK: pattern_step = ~pattern;
         MODE_CHASE: pattern_step = {pattern[N_LEDS-2:0], pattern[N_LEDS-1]};
         MODE_COUNT: pattern_step = pattern + N_LEDS'(1);
         default:    pattern_step = '0;
      endcase
   end

   // Saturating speed update; opposing presses in one cycle cancel
   always_comb begin
      speed_next = speed;
      if (press_fast && !press_slow && (speed != '0))
         speed_next = speed - SPEED_W'(1);
      else if (press_slow && !press_fast && (speed != SPEED_MAX))
         speed_next = speed + SPEED_W'(1);
   end

   assign speed_change = (speed_next != speed);

   // Speed index register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) speed <= '0;
      else        speed <= speed_next;
   end

   // Tick on the last count of the current period
   assign period      = (DIV_W+1)'(DIV_BASE) << speed;
   assign period_last = DIV_W'(period - (DIV_W+1)'(1));
   assign tick        = (div_count == period_last);

   // Divider restarts on a tick, on a mode change and on an effective speed change
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         div_count <= '0;
      else if (press_mode || speed_change || tick)
         div_count <= '0;
      else
         div_count <= div_count + DIV_W'(1);
   end

   // Pattern register: a mode change takes priority over a coincident tick
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         pattern <= '0;
      else if (press_mode)
         pattern <= pattern_init;
      else if (tick)
         pattern <= pattern_step;
   end

   assign LEDS = pattern;

endmodule

// File: tb/tb_blink_sequencer.sv
// Bench for blink_sequencer with small divider and debounce constants.
module tb_blink_sequencer;

   localparam int N_LEDS = 5;
   localparam int DIV_BASE = 4;
   localparam int DC = 3;
   localparam int MASK = (1 << N_LEDS) - 1;

   logic CLK = 1'b0;
   logic RST_N = 1'b1;
   logic BTN1 = 1'b0;
   logic BTN2 = 1'b0;
   logic BTN3 = 1'b0;
   logic [N_LEDS-1:0] LEDS;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   blink_sequencer #(
      .N_LEDS(N_LEDS),
      .DIV_BASE(DIV_BASE),
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .BTN1(BTN1),
      .BTN2(BTN2),
      .BTN3(BTN3),
      .LEDS(LEDS)
   );

   // Reference model state
   int m_mode;
   int m_s;
   int m_sc;      // edges since the divider last restarted
   int m_pat;
   bit m_tick;
   bit m_modechg;
   logic [2:0] m_lvl;
   logic [2:0] hist[$];

   function automatic int step_pat(input int mode, input int pat);
      case (mode)
         0: return pat ^ MASK;
         1: return ((pat << 1) | (pat >> (N_LEDS - 1))) & MASK;
         2: return (pat + 1) % (1 << N_LEDS);
         default: return 0;
      endcase
   endfunction

   function automatic void model_reset();
      m_mode = 0; m_s = 0; m_sc = 0; m_pat = 0;
      m_tick = 0; m_modechg = 0; m_lvl = '0;
      hist.delete();
   endfunction

   // A button's accepted level flips once DC consecutive samples (seen two
   // clocks late through the synchroniser) all disagree with it.
   function automatic void model_edge();
      logic [2:0] press;
      int p;
      int new_s;
      bit all;
      press = '0;
      hist.push_back({BTN3, BTN2, BTN1});
      if (hist.size() > DC + 2) void'(hist.pop_front());
      if (hist.size() == DC + 2) begin
         for (int b = 0; b < 3; b++) begin
            all = 1;
            for (int i = 0; i < DC; i++)
               if (hist[i][b] == m_lvl[b]) all = 0;
            if (all) begin
               m_lvl[b] = ~m_lvl[b];
               press[b] = m_lvl[b];
            end
         end
      end
      p = DIV_BASE << m_s;
      m_tick = (m_sc == p - 1);
      m_modechg = press[0];
      new_s = m_s;
      if (press[1] && !press[2] && m_s > 0) new_s = m_s - 1;
      else if (press[2] && !press[1] && m_s < 7) new_s = m_s + 1;
      if (press[0]) begin
         m_mode = (m_mode + 1) % 4;
         m_pat = (m_mode == 1) ? 1 : 0;
         m_sc = 0;
      end else begin
         if (m_tick) m_pat = step_pat(m_mode, m_pat);
         m_sc = (m_tick || new_s != m_s) ? 0 : m_sc + 1;
      end
      m_s = new_s;
   endfunction

   task automatic cycle();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   // Assert reset between edges, hold across two edges, release mid-cycle
   task automatic apply_reset();
      BTN1 = 0; BTN2 = 0; BTN3 = 0;
      RST_N = 1'b0;
      repeat (2) @(posedge CLK);
      #3;
      RST_N = 1'b1;
      model_reset();
   endtask

   task automatic press_btn(input logic [2:0] which, input int hold, input int rel);
      {BTN3, BTN2, BTN1} = which;
      repeat (hold) cycle();
      {BTN3, BTN2, BTN1} = 3'b000;
      repeat (rel) cycle();
   endtask

   // Cycles between two consecutive LEDS changes; -1 if none within the bound
   task automatic measure_period(output int per);
      logic [N_LEDS-1:0] prev;
      int n;
      bit seen;
      per = -1;
      prev = LEDS;
      seen = 0;
      for (int i = 0; i < 1200 && !seen; i++) begin
         cycle();
         if (LEDS !== prev) seen = 1;
      end
      if (seen) begin
         prev = LEDS;
         n = 0;
         seen = 0;
         for (int i = 0; i < 1200 && !seen; i++) begin
            cycle();
            n++;
            if (LEDS !== prev) seen = 1;
         end
         if (seen) per = n;
      end
   endtask

   task automatic test_reset();
      logic [N_LEDS-1:0] exp;
      #1 RST_N = 1'b0;
      #2;
      checks++;
      if (LEDS !== '0) begin
         errors++;
         $display("FAIL reset_hold: LEDS=%b expected=%b", LEDS, 5'b00000);
      end
      repeat (2) @(posedge CLK);
      #3 RST_N = 1'b1;
      model_reset();
      for (int c = 1; c <= 12; c++) begin
         cycle();
         exp = N_LEDS'(m_pat);
         checks++;
         if (LEDS !== exp) begin
            errors++;
            $display("FAIL reset_blink cycle %0d: LEDS=%b expected=%b", c, LEDS, exp);
         end
         if (c == 3 || c == 4 || c == 8) begin
            exp = (c == 4) ? 5'b11111 : 5'b00000;
            checks++;
            if (LEDS !== exp) begin
               errors++;
               $display("FAIL first_toggle cycle %0d: LEDS=%b expected=%b", c, LEDS, exp);
            end
         end
      end
   endtask

   task automatic test_chase();
      logic [N_LEDS-1:0] exp;
      int presses;
      presses = 0;
      BTN1 = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (c == 10) BTN1 = 1'b0;
         cycle();
         if (m_modechg) presses++;
         exp = N_LEDS'(m_pat);
         checks++;
         if (LEDS !== exp) begin
            errors++;
            $display("FAIL chase cycle %0d: LEDS=%b expected=%b", c, LEDS, exp);
         end
      end
      checks++;
      if (presses != 1 || m_mode != 1) begin
         errors++;
         $display("FAIL chase_single_press: presses=%0d mode=%0d expected 1/1", presses, m_mode);
      end
   endtask

   task automatic test_glitch();
      logic [N_LEDS-1:0] exp;
      int per;
      press_btn(3'b010, 2, 8);
      press_btn(3'b100, 2, 8);
      for (int c = 0; c < 12; c++) begin
         cycle();
         exp = N_LEDS'(m_pat);
         checks++;
         if (LEDS !== exp) begin
            errors++;
            $display("FAIL glitch cycle %0d: LEDS=%b expected=%b", c, LEDS, exp);
         end
      end
      measure_period(per);
      checks++;
      if (per != 4) begin
         errors++;
         $display("FAIL glitch_period: got %0d expected 4", per);
      end
   endtask

   task automatic test_speed();
      logic [N_LEDS-1:0] exp;
      int per;
      repeat (9) press_btn(3'b100, 5, 5);
      measure_period(per);
      checks++;
      if (per != 512) begin
         errors++;
         $display("FAIL speed_slowest: period %0d expected 512", per);
      end
      press_btn(3'b010, 5, 5);
      measure_period(per);
      checks++;
      if (per != 256) begin
         errors++;
         $display("FAIL speed_faster: period %0d expected 256", per);
      end
      press_btn(3'b110, 5, 5);
      measure_period(per);
      checks++;
      if (per != 256) begin
         errors++;
         $display("FAIL speed_both: period %0d expected 256", per);
      end
      exp = N_LEDS'(m_pat);
      checks++;
      if (LEDS !== exp) begin
         errors++;
         $display("FAIL speed_pattern: LEDS=%b expected=%b", LEDS, exp);
      end
   endtask

   task automatic test_count();
      logic [N_LEDS-1:0] exp;
      logic [N_LEDS-1:0] prev;
      bit seen[32];
      int distinct;
      bit wrapped;
      int target;
      bit aligned;
      apply_reset();
      press_btn(3'b001, 5, 5);
      press_btn(3'b001, 5, 5);
      wrapped = 0;
      prev = LEDS;
      for (int c = 0; c < 140; c++) begin
         cycle();
         exp = N_LEDS'(m_pat);
         checks++;
         if (LEDS !== exp) begin
            errors++;
            $display("FAIL count cycle %0d: LEDS=%b expected=%b", c, LEDS, exp);
         end
         seen[int'(LEDS)] = 1;
         if (prev == 5'b11111 && LEDS == 5'b00000) wrapped = 1;
         prev = LEDS;
      end
      distinct = 0;
      foreach (seen[i]) if (seen[i]) distinct++;
      checks++;
      if (distinct != 32 || !wrapped) begin
         errors++;
         $display("FAIL count_range: distinct=%0d wrapped=%0d expected 32/1", distinct, wrapped);
      end
      // Start the press so that its effect lands on a tick edge
      target = ((DIV_BASE - 1 - (DC + 1)) % DIV_BASE + DIV_BASE) % DIV_BASE;
      aligned = 0;
      for (int i = 0; i < 2 * DIV_BASE && !aligned; i++) begin
         if (m_sc == target) aligned = 1;
         else cycle();
      end
      BTN1 = 1'b1;
      for (int c = 0; c < DC + 2; c++) begin
         cycle();
         exp = N_LEDS'(m_pat);
         checks++;
         if (LEDS !== exp) begin
            errors++;
            $display("FAIL press_on_tick cycle %0d: LEDS=%b expected=%b", c, LEDS, exp);
         end
      end
      checks++;
      if (LEDS !== 5'b00000 || !(m_tick && m_modechg)) begin
         errors++;
         $display("FAIL off_on_tick: LEDS=%b tick=%0d press=%0d expected 00000/1/1", LEDS, m_tick, m_modechg);
      end
      BTN1 = 1'b0;
      for (int c = 0; c < 12; c++) begin
         cycle();
         checks++;
         if (LEDS !== 5'b00000) begin
            errors++;
            $display("FAIL off_stays cycle %0d: LEDS=%b expected=%b", c, LEDS, 5'b00000);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [N_LEDS-1:0] exp;
      bit found;
      apply_reset();
      press_btn(3'b001, 5, 2);
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         cycle();
         if (LEDS === 5'b00100) found = 1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL mid_reach_chase: LEDS=%b expected=%b", LEDS, 5'b00100);
      end
      #3 RST_N = 1'b0;
      #2;
      checks++;
      if (LEDS !== 5'b00000) begin
         errors++;
         $display("FAIL mid_async_reset: LEDS=%b expected=%b", LEDS, 5'b00000);
      end
      repeat (2) @(posedge CLK);
      #3 RST_N = 1'b1;
      model_reset();
      for (int c = 1; c <= 9; c++) begin
         cycle();
         exp = (c >= 4 && c < 8) ? 5'b11111 : 5'b00000;
         checks++;
         if (LEDS !== exp || LEDS !== N_LEDS'(m_pat)) begin
            errors++;
            $display("FAIL mid_restart cycle %0d: LEDS=%b expected=%b", c, LEDS, exp);
         end
      end
   endtask

   task automatic test_random();
      logic [N_LEDS-1:0] exp;
      int rem[3];
      logic [2:0] val;
      val = '0;
      rem = '{0, 0, 0};
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < 3; b++) begin
            if (rem[b] == 0) begin
               val[b] = ~val[b];
               rem[b] = $urandom_range(1, 8);
            end
            rem[b]--;
         end
         {BTN3, BTN2, BTN1} = val;
         cycle();
         exp = N_LEDS'(m_pat);
         checks++;
         if (LEDS !== exp) begin
            errors++;
            $display("FAIL random cycle %0d: LEDS=%b expected=%b", c, LEDS, exp);
         end
      end
      {BTN3, BTN2, BTN1} = 3'b000;
   endtask

   initial begin
      test_reset();
      test_chase();
      test_glitch();
      test_speed();
      test_count();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/blink_sequencer.md
BLINK_SEQUENCER -- requirements
Module: blink_sequencer

Interface
REQ-001 The block SHALL have parameter N_LEDS, default 5, meaning the number of LED outputs (2..16).
REQ-002 The block SHALL have parameter DIV_BASE, default 500000, meaning the base tick period in CLK cycles (at least 2).
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 12000, meaning the number of CLK cycles a button input must be stable to be accepted (at least 2).
REQ-004 The block SHALL have port CLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port RST_N, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have ports BTN1, BTN2 and BTN3, input, 1 bit each, asynchronous and active-high: BTN1 selects the next mode, BTN2 makes the sequence faster, BTN3 makes it slower.
REQ-007 The block SHALL have port LEDS, output, N_LEDS bits, registered, active-high LED drive.

Function
REQ-008 Each BTNx SHALL pass through a 2-flop synchroniser followed by a debouncer.
  - Debounced level changes only after DEBOUNCE_CYCLES consecutive cycles of unchanged synchronised input.
REQ-009 A debounced 0->1 transition SHALL produce a single-cycle press pulse; holding a button SHALL produce no further pulses.
REQ-010 The mode register SHALL be 2 bits and cycle in the order BLINK(0) -> CHASE(1) -> COUNT(2) -> OFF(3) -> BLINK on each BTN1 pulse.
REQ-011 The speed index s SHALL be 3 bits.
  - BTN2 pulse: s-1, saturating at 0.
  - BTN3 pulse: s+1, saturating at 7.
  - BTN2 and BTN3 pulses in the same cycle: s unchanged.
REQ-012 The tick period SHALL be P = DIV_BASE << s cycles.
  - Divider counter width: $clog2(DIV_BASE)+7 bits.
  - Counter counts 0..P-1; tick is asserted when the counter equals P-1, and the counter wraps to 0 on the same edge.
REQ-013 The pattern register SHALL update on the tick edge, and LEDS SHALL equal the pattern register at all times.
  - BLINK: all bits invert together.
  - CHASE: one-hot rotates left; the MSB wraps to bit 0.
  - COUNT: unsigned increment modulo 2^N_LEDS.
  - OFF: stays all zeros.
REQ-014 A mode change SHALL load the pattern register with the new mode's initial value and clear the divider on the same edge.
  - Initial values: BLINK 0, CHASE 1 (bit 0 set), COUNT 0, OFF 0.
REQ-015 A speed change SHALL clear the divider and leave the pattern unchanged; a saturated press that leaves s unchanged SHALL not clear the divider.
REQ-016 If a BTN1 pulse coincides with a tick, the mode change SHALL win and no pattern step SHALL occur.
  - If a speed change coincides with a tick, the tick step occurs and the divider is cleared.
REQ-017 After reset release with no button activity, the first LEDS change SHALL occur exactly DIV_BASE cycles after the first CLK edge with RST_N high.

Reset
REQ-018 While RST_N is low, the block SHALL asynchronously hold the following values:
  - mode=BLINK, s=0, divider=0, pattern=0, LEDS=0;
  - synchroniser flops, debounce counters and debounced levels at 0; no press pulses.
REQ-019 Reset asserted mid-operation SHALL take effect immediately without waiting for a clock edge; operation SHALL restart per REQ-017 after release.

Structure
REQ-020 A shared package blink_pkg SHALL hold the mode enum (MODE_BLINK/CHASE/COUNT/OFF, 2 bits), SPEED_MAX=7 and the speed-index width constant.
REQ-021 The block SHALL instantiate sub-module button_debounce three times, once per button.
  - button_debounce ports: CLK, RST_N, parameter DEBOUNCE_CYCLES, raw input, debounced level, press pulse.
  - The divider, mode, speed and pattern logic reside in blink_sequencer.

Verification (N_LEDS=5, DIV_BASE=4, DEBOUNCE_CYCLES=3)
REQ-022 Reset release with no buttons -> LEDS 00000; 11111 at cycle 4; 00000 at cycle 8; period 4 cycles.
REQ-023 BTN1 held 10 cycles -> exactly one press; LEDS=00001 on the mode edge, then 00010, 00100, 01000, 10000, 00001 every 4 cycles; hold produces no second step.
REQ-024 BTN2 glitch high for 2 cycles, then low -> no press pulse; s stays 0; period stays 4.
REQ-025 Nine BTN3 presses -> s saturates at 7; tick period 512 cycles; one BTN2 press -> period 256; simultaneous BTN2+BTN3 press -> period unchanged.
REQ-026 COUNT mode, 32 ticks -> LEDS runs 00000..11111 and wraps to 00000; a BTN1 press on a tick cycle -> OFF, LEDS=00000, no count step.
REQ-027 RST_N pulled low mid-CHASE between clock edges -> LEDS=00000 immediately; after release, mode BLINK, first toggle after 4 cycles.
